// File: rtl/spi_slave_stream_pkg.sv
// Shared types and constants for the oversampled SPI slave.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Wide enough for any practical word width; sliced to DATA_WDT at use.
  localparam logic [63:0] SPI_UNDERRUN_WORD = '0;

endpackage

// File: rtl/spi_slave_stream_if.sv
// Fabric-side TX push and RX stream handshakes of the SPI slave.
interface spi_slave_stream_if #(
  parameter int unsigned DATA_WDT = 8
);
  logic [DATA_WDT-1:0] txData;
  logic                txValid;
  logic                txReady;
  logic [DATA_WDT-1:0] rxData;
  logic                rxValid;
  logic                rxReady;

  modport master (output txData, txValid, rxReady, input txReady, rxData, rxValid);
  modport slave  (input txData, txValid, rxReady, output txReady, rxData, rxValid);
endinterface

// File: rtl/spi_slave_stream_sync.sv
// Multi-flop synchroniser for one asynchronous pin, with edge detection.
module spi_in_sync #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [DEPTH-1:0] chain;
  logic             prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {DEPTH{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[DEPTH-2:0], d};
      prev  <= chain[DEPTH-1];
    end
  end

  assign q    = chain[DEPTH-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_stream.sv
// Oversampled SPI slave: runtime CPOL/CPHA, TX FIFO, RX valid/ready stream.
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WDT   = 8,
  parameter int unsigned TX_DEPTH   = 4,
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ssel,
  input  logic                          sclk,
  input  logic                          mosi,
  output logic                          miso,
  input  logic                          cpol,
  input  logic                          cpha,
  spi_slave_stream_if.slave             bus,
  output logic [$clog2(TX_DEPTH+1)-1:0] txLevel,
  output logic                          spiBusy,
  output logic                          spiStart,
  output logic                          spiEnd,
  output logic                          txUnderrun,
  output logic                          rxOverrun
);
  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned CW = $clog2(TX_DEPTH + 1);
  localparam int unsigned BW = $clog2(DATA_WDT);

  logic ssel_unused_q, ssel_rise, ssel_fall;
  logic sclk_unused_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_unused_rise, mosi_unused_fall;

  spi_in_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_ssel (
    .clk(clk), .rst_n(reset), .d(ssel), .q(ssel_unused_q), .rise(ssel_rise), .fall(ssel_fall));
  spi_in_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(reset), .d(sclk), .q(sclk_unused_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_in_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(reset), .d(mosi), .q(mosi_q), .rise(mosi_unused_rise), .fall(mosi_unused_fall));

  spi_state_t          state, state_nxt;
  spi_mode_t           mode;
  logic [BW-1:0]       bitcnt;
  logic [DATA_WDT-1:0] rx_sr, tx_sr, rx_data;
  logic                rx_valid, rx_done;
  logic                start, stop, sample, load, shift;
  logic                lead_e, trail_e, sample_e, shift_e, word_last;

  logic [DATA_WDT-1:0] mem [TX_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                push, pop, empty;

  assign lead_e    = mode.cpol ? sclk_fall : sclk_rise;
  assign trail_e   = mode.cpol ? sclk_rise : sclk_fall;
  assign sample_e  = mode.cpha ? trail_e : lead_e;
  assign shift_e   = mode.cpha ? lead_e : trail_e;
  assign word_last = (bitcnt == BW'(DATA_WDT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Shift edges at bit 0 either load the next word (CPHA=1) or are swallowed (CPHA=0).
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    sample    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: if (ssel_fall) begin
        state_nxt = ACTIVE;
        start     = 1'b1;
        load      = !cpha;
      end
      ACTIVE: if (ssel_rise) begin
        state_nxt = IDLE;
        stop      = 1'b1;
      end else begin
        sample = sample_e;
        if (sample_e && !mode.cpha && word_last) load = 1'b1;
        if (shift_e) begin
          if (bitcnt == '0) load  = mode.cpha;
          else              shift = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign empty       = (count == '0);
  assign bus.txReady = (count != CW'(TX_DEPTH));
  assign push        = bus.txValid && bus.txReady;
  assign pop         = load && !empty;
  assign txLevel     = count;
  assign spiBusy     = (state == ACTIVE);
  assign bus.rxData  = rx_data;
  assign bus.rxValid = rx_valid;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.txData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode       <= '0;
      bitcnt     <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      rx_done    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      miso       <= 1'b0;
      spiStart   <= 1'b0;
      spiEnd     <= 1'b0;
      txUnderrun <= 1'b0;
      rxOverrun  <= 1'b0;
    end else begin
      spiStart   <= start;
      spiEnd     <= stop;
      txUnderrun <= load && empty;
      rxOverrun  <= rx_done && rx_valid;
      rx_done    <= sample && word_last;
      miso       <= (state == ACTIVE) ? tx_sr[DATA_WDT-1] : 1'b0;

      if (start) begin
        mode   <= spi_mode_t'{cpol: cpol, cpha: cpha};
        bitcnt <= '0;
      end
      if (stop) begin
        bitcnt <= '0;
        rx_sr  <= '0;
        tx_sr  <= '0;
      end
      if (sample) begin
        rx_sr  <= {rx_sr[DATA_WDT-2:0], mosi_q};
        bitcnt <= word_last ? '0 : bitcnt + BW'(1);
      end
      if (load)       tx_sr <= empty ? SPI_UNDERRUN_WORD[DATA_WDT-1:0] : mem[rd_ptr];
      else if (shift) tx_sr <= {tx_sr[DATA_WDT-2:0], 1'b0};

      // A completed word only lands when the holding slot is free.
      if (rx_done && !rx_valid) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
      end else if (rx_valid && bus.rxReady) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_stream.sv
// Self-checking bench for spi_slave_stream: vector table, random frames vs. a queue model, corner sequences.
module tb_spi_slave_stream;
  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 2;
  localparam int H = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic ssel = 1'b1, sclk = 1'b0, mosi = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic miso, spiBusy, spiStart, spiEnd, txUnderrun, rxOverrun;
  logic [2:0] txLevel;

  spi_slave_stream_if #(.DATA_WDT(W)) bus ();

  spi_slave_stream #(.DATA_WDT(W), .TX_DEPTH(D), .SYNC_DEPTH(S)) dut (
    .clk(clk), .reset(reset), .ssel(ssel), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cpol(cpol), .cpha(cpha), .bus(bus), .txLevel(txLevel), .spiBusy(spiBusy),
    .spiStart(spiStart), .spiEnd(spiEnd), .txUnderrun(txUnderrun), .rxOverrun(rxOverrun));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_start = 0, n_end = 0, n_und = 0, n_ovr = 0, n_push = 0;
  logic [7:0] rxq[$];
  logic [7:0] mq[$];
  int exp_und;

  always @(negedge clk) begin
    if (reset) begin
      n_start += int'(spiStart);
      n_end   += int'(spiEnd);
      n_und   += int'(txUnderrun);
      n_ovr   += int'(rxOverrun);
      if (bus.rxValid && bus.rxReady) rxq.push_back(bus.rxData);
      if (bus.txValid && bus.txReady) n_push++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_counts();
    n_start = 0; n_end = 0; n_und = 0; n_ovr = 0; n_push = 0;
    rxq.delete();
  endtask

  // Reference FIFO: a push is accepted only when the model holds fewer than D words.
  task automatic push_word(input logic [7:0] w);
    bus.txData  = w;
    bus.txValid = 1'b1;
    tick();
    bus.txValid = 1'b0;
    if (mq.size() < D) mq.push_back(w);
  endtask

  task automatic model_load(output logic [7:0] w);
    if (mq.size() != 0) w = mq.pop_front();
    else begin
      w = 8'h00;
      exp_und++;
    end
  endtask

  task automatic frame_begin(input logic p, input logic h);
    cpol = p; cpha = h; sclk = p;
    wait_clk(2);
    ssel = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_end();
    wait_clk(H);
    ssel = 1'b1;
    wait_clk(H);
  endtask

  task automatic xfer_bits(input int nb, input logic [31:0] mo, output logic [31:0] mi);
    mi = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        wait_clk(H);
        sclk = ~cpol;
        mi = {mi[30:0], miso};
        wait_clk(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[i];
        wait_clk(H);
        sclk = cpol;
        mi = {mi[30:0], miso};
        wait_clk(H);
      end
    end
  endtask

  task automatic run_frame(input logic p, input logic h, input int nw,
                           input logic [31:0] mo, output logic [31:0] mi);
    frame_begin(p, h);
    xfer_bits(nw * 8, mo, mi);
    frame_end();
  endtask

  // Master-side expectation: first nw loads reach the pins; CPHA=0 also loads after the last word.
  task automatic model_frame(input logic h, input int nw, output logic [31:0] exp_mi);
    logic [7:0] w;
    exp_mi = '0;
    for (int k = 0; k < (h ? nw : nw + 1); k++) begin
      model_load(w);
      if (k < nw) exp_mi = {exp_mi[23:0], w};
    end
  endtask

  task automatic chk_rx(input string nm, input int nw, input logic [31:0] mo);
    chk({nm, "_rxcount"}, rxq.size(), nw);
    for (int k = 0; k < nw && k < rxq.size(); k++)
      chk({nm, "_rxword"}, rxq[k], mo[8*(nw-1-k) +: 8]);
  endtask

  typedef struct {
    logic        p, h;
    int          nw, npush;
    logic [31:0] push;
    logic [31:0] mo;
    logic [31:0] exp_mi;
    int          exp_und;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [31:0] mi, mo, emi;
    int nw, np, push_before;
    logic p, h;

    bus.txData = '0; bus.txValid = 1'b0; bus.rxReady = 1'b1;
    wait_clk(3);
    chk("rst_miso", miso, 0);
    chk("rst_rxvalid", bus.rxValid, 0);
    chk("rst_txready", bus.txReady, 1);
    reset = 1'b1;
    wait_clk(3);
    chk("idle_busy", spiBusy, 0);
    chk("idle_level", txLevel, 0);
    chk("idle_rxdata", bus.rxData, 0);
    chk("idle_pulses", {spiStart, spiEnd, txUnderrun, rxOverrun}, 0);

    vt[0] = '{1'b0, 1'b0, 1, 1, 32'h000000A5, 32'h0000003C, 32'h000000A5, 1};
    vt[1] = '{1'b0, 1'b0, 3, 3, 32'h00332211, 32'h00C35A96, 32'h00112233, 1};
    vt[2] = '{1'b0, 1'b1, 3, 3, 32'h00332211, 32'h00817EFF, 32'h00112233, 0};
    vt[3] = '{1'b1, 1'b0, 3, 3, 32'h00332211, 32'h00000180, 32'h00112233, 1};
    vt[4] = '{1'b1, 1'b1, 3, 3, 32'h00332211, 32'h00A5F00F, 32'h00112233, 0};
    vt[5] = '{1'b0, 1'b1, 2, 1, 32'h00000055, 32'h0000F00F, 32'h00005500, 1};

    for (int i = 0; i < 6; i++) begin
      clr_counts();
      for (int k = 0; k < vt[i].npush; k++) push_word(vt[i].push[8*k +: 8]);
      chk($sformatf("v%0d_level_pre", i), txLevel, vt[i].npush);
      run_frame(vt[i].p, vt[i].h, vt[i].nw, vt[i].mo, mi);
      chk($sformatf("v%0d_miso", i), mi, vt[i].exp_mi);
      chk($sformatf("v%0d_underrun", i), n_und, vt[i].exp_und);
      chk($sformatf("v%0d_start_end", i), {n_start[15:0], n_end[15:0]}, 32'h00010001);
      chk($sformatf("v%0d_level_post", i), txLevel, 0);
      chk_rx($sformatf("v%0d", i), vt[i].nw, vt[i].mo);
    end
    mq.delete();

    for (int it = 0; it < 8; it++) begin
      clr_counts();
      exp_und = 0;
      np = $urandom_range(D - mq.size(), 0);
      for (int k = 0; k < np; k++) push_word(8'($urandom));
      p = 1'($urandom); h = 1'($urandom);
      nw = $urandom_range(3, 1);
      mo = $urandom;
      if (nw < 4) mo &= (32'h1 << (nw * 8)) - 32'h1;
      model_frame(h, nw, emi);
      run_frame(p, h, nw, mo, mi);
      chk($sformatf("rnd%0d_miso", it), mi, emi);
      chk($sformatf("rnd%0d_underrun", it), n_und, exp_und);
      chk($sformatf("rnd%0d_level", it), txLevel, mq.size());
      chk_rx($sformatf("rnd%0d", it), nw, mo);
    end

    clr_counts();
    bus.rxReady = 1'b0;
    model_frame(1'b0, 2, emi);
    run_frame(1'b0, 1'b0, 2, 32'h00000102, mi);
    chk("ovr_rxdata", bus.rxData, 8'h01);
    chk("ovr_rxvalid", bus.rxValid, 1);
    chk("ovr_pulses", n_ovr, 1);
    bus.rxReady = 1'b1;
    wait_clk(2);
    chk("ovr_drain_valid", bus.rxValid, 0);
    chk_rx("ovr", 1, 32'h01);

    clr_counts();
    while (mq.size() < D) push_word(8'($urandom));
    chk("full_ready", bus.txReady, 0);
    chk("full_level", txLevel, D);
    push_before = n_push;
    bus.txData = 8'hE7; bus.txValid = 1'b1;
    frame_begin(1'b0, 1'b0);
    bus.txValid = 1'b0;
    model_load(emi[7:0]);
    mq.push_back(8'hE7);
    chk("full_one_push", n_push - push_before, 1);
    chk("full_level_hold", txLevel, D);
    chk("full_ready_hold", bus.txReady, 0);
    frame_end();
    exp_und = 0;
    model_frame(1'b1, 4, emi);
    run_frame(1'b0, 1'b1, 4, 32'h0, mi);
    chk("full_drain_order", mi, emi);
    chk("full_drain_level", txLevel, 0);

    clr_counts();
    frame_begin(1'b0, 1'b0);
    xfer_bits(5, 32'h16, mi);
    frame_end();
    model_frame(1'b0, 0, emi);
    chk("abort_rxvalid", bus.rxValid, 0);
    chk("abort_rxcount", rxq.size(), 0);
    chk("abort_end", n_end, 1);
    model_frame(1'b0, 1, emi);
    run_frame(1'b0, 1'b0, 1, 32'h9D, mi);
    chk_rx("realign", 1, 32'h9D);

    push_word(8'h3A); push_word(8'hC5);
    frame_begin(1'b1, 1'b1);
    xfer_bits(3, 32'h5, mi);
    reset = 1'b0;
    wait_clk(1);
    chk("mrst_miso", miso, 0);
    chk("mrst_busy", spiBusy, 0);
    chk("mrst_level", txLevel, 0);
    chk("mrst_ready", bus.txReady, 1);
    chk("mrst_rx", {bus.rxValid, bus.rxData}, 0);
    chk("mrst_pulses", {spiStart, spiEnd, txUnderrun, rxOverrun}, 0);
    ssel = 1'b1; sclk = 1'b0; mosi = 1'b0;
    mq.delete();
    wait_clk(2);
    reset = 1'b1;
    wait_clk(8);
    chk("post_rst_busy", spiBusy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
